// File: rtl/bk_multiword_adder_seq.sv
// Sequential multi-word adder: one 32-bit Brent-Kung slice per cycle, LSW first, carry chained
// through a register. Optional signed-overflow output enabled by defining BK_SIGNED_OVF_EN.

module brent_kung32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] out,
  output logic        cout
);
  logic [31:0] w_g;
  logic [31:0] w_p;
  logic [31:0] w_c;

  // Up-sweep builds power-of-two group terms; down-sweep fills the remaining prefixes in place.
  // NOTE: every variable gets a default at the top of always_comb so no latch can be inferred.
  always_comb begin
    w_g = a & b;
    w_p = a ^ b;
    for (int l = 1; l <= 5; l++) begin
      for (int i = 0; i < 32; i++) begin
        if (((i + 1) % (1 << l)) == 0) begin
          w_g[i] = w_g[i] | (w_p[i] & w_g[i-(1<<(l-1))]);
          w_p[i] = w_p[i] & w_p[i-(1<<(l-1))];
        end
      end
    end
    for (int l = 4; l >= 1; l--) begin
      for (int i = 0; i < 32; i++) begin
        if ((((i + 1) % (1 << l)) == (1 << (l - 1))) && (i >= (1 << l))) begin
          w_g[i] = w_g[i] | (w_p[i] & w_g[i-(1<<(l-1))]);
          w_p[i] = w_p[i] & w_p[i-(1<<(l-1))];
        end
      end
    end
  end

  // w_c[i] is the carry into bit i+1, folding cin in as a generate below bit 0.
  assign w_c  = w_g | (w_p & {32{cin}});
  assign out  = (a ^ b) ^ {w_c[30:0], cin};
  assign cout = w_c[31];
endmodule

module bk_multiword_adder_seq #(
  parameter int WORDS = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORDS*32-1:0]   a,
  input  logic [WORDS*32-1:0]   b,
  input  logic                  cin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORDS*32-1:0]   sum,
`ifdef BK_SIGNED_OVF_EN
  output logic                  ovf,
`endif
  output logic                  cout
);
  localparam int W  = WORDS * 32;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [IW-1:0]   r_idx;
  logic            r_carry;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_sum;
  logic            r_cout;
  logic            w_accept;
  logic            w_last;
  logic [31:0]     w_add_out;
  logic            w_add_cout;

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign w_accept  = in_valid && in_ready;
  assign w_last    = (r_idx == IW'(WORDS - 1));
  assign sum       = r_sum;
  assign cout      = r_cout;

  brent_kung32 u_add (
    r_a[int'(r_idx)*32 +: 32],
    r_b[int'(r_idx)*32 +: 32],
    r_carry,
    w_add_out,
    w_add_cout
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept)  w_state_nxt = ST_RUN;
      ST_RUN:  if (w_last)    w_state_nxt = ST_DONE;
      ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
      default:                w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: operand registers carry no reset; they are always loaded before being read.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_a <= a;
      r_b <= b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else if (w_accept) begin
      r_idx   <= '0;
      r_carry <= cin;
    end else if (r_state == ST_RUN) begin
      r_sum[int'(r_idx)*32 +: 32] <= w_add_out;
      r_carry                     <= w_add_cout;
      r_idx                       <= w_last ? '0 : r_idx + 1'b1;
      if (w_last) r_cout <= w_add_cout;
    end
  end

`ifdef BK_SIGNED_OVF_EN
  logic r_ovf;
  assign ovf = r_ovf;

  // Overflow only when both operands share a sign and the result sign differs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if ((r_state == ST_RUN) && w_last) begin
      r_ovf <= (r_a[W-1] == r_b[W-1]) && (w_add_out[31] != r_a[W-1]);
    end
  end
`endif
endmodule

// File: tb/tb_bk_multiword_adder_seq.sv
// Self-checking bench: directed cases on a WORDS=2 instance, then random traffic on
// WORDS=1,2,4 instances compared against plain a+b+cin arithmetic.

module tb_bk_multiword_adder_seq;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;
  logic go = 1'b0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // ---------------- directed instance, WORDS=2 ----------------
  logic        d_in_valid, d_in_ready, d_cin, d_out_valid, d_out_ready, d_cout;
  logic [63:0] d_a, d_b, d_sum;
`ifdef BK_SIGNED_OVF_EN
  logic        d_ovf;
`endif

  bk_multiword_adder_seq #(.WORDS(2)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (d_in_valid),
    .in_ready  (d_in_ready),
    .a         (d_a),
    .b         (d_b),
    .cin       (d_cin),
    .out_valid (d_out_valid),
    .out_ready (d_out_ready),
    .sum       (d_sum),
`ifdef BK_SIGNED_OVF_EN
    .ovf       (d_ovf),
`endif
    .cout      (d_cout)
  );

  task automatic d_send(input logic [63:0] ta, input logic [63:0] tb, input logic tc);
    @(negedge clk);
    d_a = ta; d_b = tb; d_cin = tc; d_in_valid = 1'b1;
    @(posedge clk);
    #1 d_in_valid = 1'b0;
    d_a = 64'hDEAD_BEEF_0BAD_F00D; d_b = 64'h0;
  endtask

  task automatic d_wait_done(input string tag);
    int g = 0;
    while (!d_out_valid && g < 20) begin
      @(negedge clk);
      g++;
    end
    check({tag, "_done"}, d_out_valid, 1'b1);
  endtask

  task automatic d_take();
    @(negedge clk);
    d_out_ready = 1'b1;
    @(posedge clk);
    #1 d_out_ready = 1'b0;
  endtask

  // ---------------- random instances, WORDS=1,2,4 ----------------
  for (genvar gi = 0; gi < 3; gi++) begin : g_rand
    localparam int WD = 1 << gi;
    localparam int WW = WD * 32;
    logic          iv, ir, ci, ov, ordy, co;
    logic [WW-1:0] ra, rb, s;
`ifdef BK_SIGNED_OVF_EN
    logic          of;
`endif

    bk_multiword_adder_seq #(.WORDS(WD)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (iv),
      .in_ready  (ir),
      .a         (ra),
      .b         (rb),
      .cin       (ci),
      .out_valid (ov),
      .out_ready (ordy),
      .sum       (s),
`ifdef BK_SIGNED_OVF_EN
      .ovf       (of),
`endif
      .cout      (co)
    );

    initial begin
      logic [WW:0]   exp;
      logic [WW-1:0] ta, tb;
      logic          tc, got;
      string         tag;
      int            g;
      iv = 1'b0; ordy = 1'b0; ra = '0; rb = '0; ci = 1'b0;
      tag = $sformatf("rand_w%0d", WD);
      wait (go);
      for (int n = 0; n < 350; n++) begin
        for (int k = 0; k < WD; k++) begin
          ta[k*32 +: 32] = $urandom;
          tb[k*32 +: 32] = $urandom;
        end
        case ($urandom_range(0, 5))
          0:       tb = ~ta;
          1:       ta = '1;
          2:       begin ta = {1'b0, {(WW-1){1'b1}}}; tb = '0; tb[0] = 1'b1; end
          default: ;
        endcase
        tc  = 1'($urandom_range(0, 1));
        exp = {1'b0, ta} + {1'b0, tb} + {{WW{1'b0}}, tc};

        @(negedge clk);
        g = 0;
        while (!ir && g < 50) begin
          @(negedge clk);
          g++;
        end
        check({tag, "_in_ready"}, ir, 1'b1);
        ra = ta; rb = tb; ci = tc; iv = 1'b1;
        @(posedge clk);
        #1 iv = 1'b0;
        ra = ~ta; rb = $urandom; ci = ~tc;

        got = 1'b0;
        g   = 0;
        while (!got && g < 100) begin
          @(negedge clk);
          ordy = 1'($urandom_range(0, 1));
          if (ov && ordy) begin
            check({tag, "_sum"}, {co, s}, exp);
`ifdef BK_SIGNED_OVF_EN
            check({tag, "_ovf"}, of,
                  (ta[WW-1] == tb[WW-1]) && (exp[WW-1] != ta[WW-1]));
`endif
            got = 1'b1;
          end
          g++;
        end
        check({tag, "_result_seen"}, got, 1'b1);
        @(posedge clk);
        #1 ordy = 1'b0;
      end
      done_cnt++;
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [64:0] exp;
    int          g;
    rst_n = 1'b0;
    d_in_valid = 1'b0; d_out_ready = 1'b0; d_a = '0; d_b = '0; d_cin = 1'b0;
    #12;
    check("rst_in_ready",  d_in_ready, 1'b1);
    check("rst_out_valid", d_out_valid, 1'b0);
    check("rst_sum",       {d_cout, d_sum}, 65'h0);
`ifdef BK_SIGNED_OVF_EN
    check("rst_ovf", d_ovf, 1'b0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // carry crossing the slice boundary, and exact latency
    d_send(64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0);
    check("lat_in_ready_run", d_in_ready, 1'b0);
    @(posedge clk); #1;
    check("lat_edge1_valid", d_out_valid, 1'b0);
    @(posedge clk); #1;
    check("lat_edge2_valid", d_out_valid, 1'b1);
    check("t1_sum", {d_cout, d_sum}, 65'h0_0000_0001_0000_0000);
    d_take();
    check("t1_in_ready_after", d_in_ready, 1'b1);

    // carry ripples out of the top slice
    d_send(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1);
    d_wait_done("t2");
    check("t2_sum", {d_cout, d_sum}, 65'h1_0000_0000_0000_0000);
`ifdef BK_SIGNED_OVF_EN
    check("t2_ovf", d_ovf, 1'b0);
`endif
    d_take();

    // held result under back-pressure while new operands are offered
    exp = {1'b0, 64'h1234_5678_9ABC_DEF0} + {1'b0, 64'h1111_1111_1111_1111} + 65'd1;
    d_send(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b1);
    d_wait_done("t3");
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      d_in_valid = 1'b1; d_a = {$urandom, $urandom}; d_b = {$urandom, $urandom};
      #1;
      check("t3_stall_in_ready", d_in_ready, 1'b0);
      check("t3_stall_valid",    d_out_valid, 1'b1);
      check("t3_stall_sum",      {d_cout, d_sum}, exp);
    end
    @(negedge clk);
    d_in_valid = 1'b0;
    d_take();
    check("t3_in_ready_after", d_in_ready, 1'b1);
    check("t3_valid_after",    d_out_valid, 1'b0);

    // reset after slice 0 abandons the operation
    d_send(64'hAAAA_AAAA_5555_5555, 64'h5555_5555_AAAA_AAAB, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("t4_rst_valid",    d_out_valid, 1'b0);
    check("t4_rst_sum",      {d_cout, d_sum}, 65'h0);
    check("t4_rst_in_ready", d_in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    d_send(64'd3, 64'd4, 1'b0);
    d_wait_done("t4b");
    check("t4b_sum", {d_cout, d_sum}, 65'd7);
    d_take();

    // signed overflow at the top slice
    d_send(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
    d_wait_done("t5");
    check("t5_sum", {d_cout, d_sum}, 65'h0_8000_0000_0000_0000);
`ifdef BK_SIGNED_OVF_EN
    check("t5_ovf", d_ovf, 1'b1);
`endif
    d_take();

    go = 1'b1;
    g  = 0;
    while (done_cnt < 3 && g < 60000) begin
      @(negedge clk);
      g++;
    end
    check("rand_all_finished", done_cnt, 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
